// File: rtl/fatori_mon_voter_quarantine.sv
// ---------------------------------------------------------------------------
// fatori_mon_voter_quarantine
//
// Purpose:
//    M-of-N bitwise voter with per-replica health tracking. Every replica bus
//    is voted bit by bit. Only replicas in the ACTIVE state take part in the
//    vote. A replica that disagrees with the voted output for MISMATCH_LIMIT
//    consecutive cycles is quarantined, which removes it from the vote. A
//    quarantined replica comes back only after two things happen. First, a
//    rejoin request moves it into probation. Second, it agrees with the vote
//    for RESYNC_CYCLES consecutive cycles. This module replaces the plain
//    voter in the fatori_mon_wrap_* wrappers.
//
// Ports:
//    clk_i              clock
//    rst_ni             asynchronous active-low reset
//    replicas_i         packed [N-1:0][W-1:0] replica buses
//    rejoin_i           per-replica rejoin request (level)
//    clr_cnt_i          synchronous clear of every error counter
//    y_o                voted output (combinational)
//    min_err_o          an active replica was out-voted while every bit had a majority
//    maj_err_o          at least one bit had no M-agreeing active replicas
//    scrub_occurred_o   registered: the previous cycle masked a fault
//    replica_active_o   1 = replica takes part in the vote
//    quarantine_o       one-cycle pulse in the cycle a replica is quarantined
//    degraded_o         active count == M, so no further quarantine is possible
//    err_cnt_o          saturating mismatch counters, field g at [g*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module fatori_mon_voter_quarantine #(
   parameter int W              = 32,
   parameter int N              = 3,
   parameter int M              = 2,
   parameter int HOLD           = 0,
   parameter int MISMATCH_LIMIT = 4,
   parameter int RESYNC_CYCLES  = 8,
   parameter int CNT_W          = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [N-1:0][W-1:0]   replicas_i,
   input  logic [N-1:0]          rejoin_i,
   input  logic                  clr_cnt_i,
   output logic [W-1:0]          y_o,
   output logic                  min_err_o,
   output logic                  maj_err_o,
   output logic                  scrub_occurred_o,
   output logic [N-1:0]          replica_active_o,
   output logic [N-1:0]          quarantine_o,
   output logic                  degraded_o,
   output logic [N*CNT_W-1:0]    err_cnt_o
);

   localparam int RW = $clog2(MISMATCH_LIMIT + 1);
   localparam int AW = $clog2(RESYNC_CYCLES + 1);

   if (N < 1) begin : g_bad_n
      $error("fatori_mon_voter_quarantine: N must be >= 1");
   end
   if ((M < 1) || (M > N) || (2 * M <= N)) begin : g_bad_m
      $error("fatori_mon_voter_quarantine: need 1 <= M <= N and 2*M > N");
   end
   if (MISMATCH_LIMIT < 1) begin : g_bad_limit
      $error("fatori_mon_voter_quarantine: MISMATCH_LIMIT must be >= 1");
   end
   if (RESYNC_CYCLES < 1) begin : g_bad_resync
      $error("fatori_mon_voter_quarantine: RESYNC_CYCLES must be >= 1");
   end
   if (CNT_W < 1) begin : g_bad_cntw
      $error("fatori_mon_voter_quarantine: CNT_W must be >= 1");
   end

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_QUAR   = 2'd1,
      ST_PROB   = 2'd2
   } repState_e;

   repState_e                 state_q [N];
   repState_e                 state_d [N];
   logic [N-1:0][RW-1:0]      run_q, run_d;
   logic [N-1:0][AW-1:0]      agree_q, agree_d;
   logic [N-1:0][CNT_W-1:0]   errCnt_q, errCnt_d;
   logic [W-1:0]              hold_q;
   logic                      scrub_q;

   logic [N-1:0]              activeVec;
   int                        activeCnt;
   logic [W-1:0]              fallback;
   logic [W-1:0]              noMaj;
   logic [N-1:0]              mismatch;

   always_comb begin
      activeCnt = 0;
      for (int g = 0; g < N; g++) begin
         activeVec[g] = (state_q[g] == ST_ACTIVE);
         if (state_q[g] == ST_ACTIVE) begin
            activeCnt++;
         end
      end
   end

   // The fallback is the lowest-index active replica. It is only used when a
   // bit has no majority and HOLD is 0. At least M replicas are always active,
   // so the replica 0 default is never actually selected.
   always_comb begin
      fallback = replicas_i[0];
      for (int g = N - 1; g >= 0; g--) begin
         if (activeVec[g]) begin
            fallback = replicas_i[g];
         end
      end
   end

   always_comb begin : p_vote
      int ones;
      int zeros;
      y_o   = '0;
      noMaj = '0;
      ones  = 0;
      zeros = 0;
      for (int b = 0; b < W; b++) begin
         ones  = 0;
         zeros = 0;
         for (int g = 0; g < N; g++) begin
            if (activeVec[g]) begin
               if (replicas_i[g][b]) begin
                  ones++;
               end else begin
                  zeros++;
               end
            end
         end
         if (ones >= M) begin
            y_o[b] = 1'b1;
         end else if (zeros >= M) begin
            y_o[b] = 1'b0;
         end else begin
            noMaj[b] = 1'b1;
            y_o[b]   = (HOLD != 0) ? hold_q[b] : fallback[b];
         end
      end
   end

   always_comb begin
      for (int g = 0; g < N; g++) begin
         mismatch[g] = (replicas_i[g] != y_o);
      end
   end

   assign maj_err_o        = |noMaj;
   assign min_err_o        = !maj_err_o && |(mismatch & activeVec);
   assign scrub_occurred_o = scrub_q;
   assign replica_active_o = activeVec;
   assign degraded_o       = (activeCnt == M);
   assign err_cnt_o        = errCnt_q;

   // Per-replica health FSM. Quarantine grants are issued in ascending index
   // order. grantCnt tracks how many lower-index replicas have already been
   // quarantined this cycle. This keeps the active pool from dropping below M.
   // The run counter is saturated before it is compared with the limit. As a
   // result, a replica that was refused quarantine while degraded is
   // quarantined on its next mismatch once the pool allows it.
   always_comb begin : p_health
      int grantCnt;
      logic [RW-1:0] runInc;
      grantCnt     = 0;
      runInc       = '0;
      state_d      = state_q;
      run_d        = run_q;
      agree_d      = agree_q;
      errCnt_d     = errCnt_q;
      quarantine_o = '0;
      for (int g = 0; g < N; g++) begin
         case (state_q[g])
            ST_ACTIVE: begin
               if (mismatch[g]) begin
                  if (errCnt_q[g] != {CNT_W{1'b1}}) begin
                     errCnt_d[g] = errCnt_q[g] + CNT_W'(1);
                  end
                  runInc = (run_q[g] == RW'(MISMATCH_LIMIT)) ? run_q[g] : run_q[g] + RW'(1);
                  if ((runInc == RW'(MISMATCH_LIMIT)) && ((activeCnt - grantCnt) > M)) begin
                     state_d[g]      = ST_QUAR;
                     run_d[g]        = '0;
                     quarantine_o[g] = 1'b1;
                     grantCnt++;
                  end else begin
                     run_d[g] = runInc;
                  end
               end else begin
                  run_d[g] = '0;
               end
            end
            ST_QUAR: begin
               if (rejoin_i[g]) begin
                  state_d[g] = ST_PROB;
                  agree_d[g] = '0;
               end
            end
            ST_PROB: begin
               if (mismatch[g]) begin
                  agree_d[g] = '0;
               end else if (agree_q[g] + AW'(1) == AW'(RESYNC_CYCLES)) begin
                  state_d[g] = ST_ACTIVE;
                  run_d[g]   = '0;
                  agree_d[g] = '0;
               end else begin
                  agree_d[g] = agree_q[g] + AW'(1);
               end
            end
            default: begin
               state_d[g] = ST_ACTIVE;
               run_d[g]   = '0;
               agree_d[g] = '0;
            end
         endcase
         if (clr_cnt_i) begin
            errCnt_d[g] = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int g = 0; g < N; g++) begin
            state_q[g] <= ST_ACTIVE;
         end
         run_q    <= '0;
         agree_q  <= '0;
         errCnt_q <= '0;
         hold_q   <= '0;
         scrub_q  <= 1'b0;
      end else begin
         for (int g = 0; g < N; g++) begin
            state_q[g] <= state_d[g];
         end
         run_q    <= run_d;
         agree_q  <= agree_d;
         errCnt_q <= errCnt_d;
         hold_q   <= y_o;
         scrub_q  <= min_err_o && !maj_err_o;
      end
   end

endmodule
